// File: rtl/irq_pkg.sv
// Shared types for the interrupt path: the event coalescer upstream and the
// interrupt generator downstream import this one package.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLDOFF = 2'd2
    } coal_state_t;

    // Output mode of the downstream interrupt generator.
    typedef enum logic [1:0] {
        IRQ_MODE_LEVEL = 2'd0,
        IRQ_MODE_PULSE = 2'd1,
        IRQ_MODE_EDGE  = 2'd2
    } irq_mode_t;

endpackage

// File: rtl/irq_edge_detect.sv
// Per-source edge/level event detection; the previous-level register tracks
// the inputs even while disabled so re-enabling never produces a false edge.
module irq_edge_detect #(
    parameter int STATUS_W = 32
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                enable_i,
    input  logic [STATUS_W-1:0] event_i,
    input  logic [STATUS_W-1:0] edge_en_i,
    output logic [STATUS_W-1:0] det_o
);

    logic [STATUS_W-1:0] r_event_q;
    logic [STATUS_W-1:0] w_rise;
    logic [STATUS_W-1:0] w_sel;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_event_q <= '0;
        end else begin
            r_event_q <= event_i;
        end
    end

    assign w_rise = event_i & ~r_event_q;
    assign w_sel  = (edge_en_i & w_rise) | (~edge_en_i & event_i);
    assign det_o  = enable_i ? w_sel : '0;

endmodule

// File: rtl/irq_event_coalescer.sv
// Batches detected source events into single-cycle status pulses, fired on an
// event-count threshold or timeout, with an optional holdoff between fires.
module irq_event_coalescer
    import irq_pkg::*;
#(
    parameter int STATUS_W = 32,
    parameter int CNT_W    = 8,
    parameter int TMR_W    = 16
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                enable_i,
    input  logic [STATUS_W-1:0] event_i,
    input  logic [STATUS_W-1:0] edge_en_i,
    input  logic [CNT_W-1:0]    thresh_i,
    input  logic [TMR_W-1:0]    timeout_i,
    input  logic [TMR_W-1:0]    holdoff_i,
    input  logic [STATUS_W-1:0] pend_clr_i,
    input  logic                ovf_clr_i,
    output logic [STATUS_W-1:0] status_o,
    output logic [STATUS_W-1:0] pending_o,
    output logic                overflow_o,
    output coal_state_t         dbg_state_o
);

    coal_state_t         r_state;
    logic [STATUS_W-1:0] r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [TMR_W-1:0]    r_timer;
    logic [TMR_W-1:0]    r_hold;
    logic [STATUS_W-1:0] r_status;
    logic [STATUS_W-1:0] r_pending;
    logic                r_overflow;

    coal_state_t         w_state_nxt;
    logic [STATUS_W-1:0] w_acc_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [TMR_W-1:0]    w_timer_nxt;
    logic [TMR_W-1:0]    w_hold_nxt;
    logic [STATUS_W-1:0] w_status_nxt;

    logic [STATUS_W-1:0] w_det;
    logic [STATUS_W-1:0] w_acc_det;
    logic                w_any;
    logic                w_cnt_max;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic [CNT_W-1:0]    w_thresh_eff;
    logic                w_timeout_hit;
    logic                w_fire;
    logic                w_ovf_set;

    irq_edge_detect #(
        .STATUS_W (STATUS_W)
    ) u_edge_detect (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .enable_i  (enable_i),
        .event_i   (event_i),
        .edge_en_i (edge_en_i),
        .det_o     (w_det)
    );

    assign w_any     = |w_det;
    assign w_acc_det = r_acc | w_det;
    assign w_cnt_max = (r_cnt == {CNT_W{1'b1}});
    // Counts cycles with any event, not the number of sources per cycle.
    assign w_cnt_inc = (w_any && !w_cnt_max) ? r_cnt + CNT_W'(1) : r_cnt;
    assign w_ovf_set = w_any & w_cnt_max;

    // A zero threshold behaves like one: fire on the first COLLECT cycle.
    assign w_thresh_eff  = (thresh_i == '0) ? CNT_W'(1) : thresh_i;
    assign w_timeout_hit = (timeout_i != '0) && (r_timer == '0);
    assign w_fire        = (r_state == COLLECT) &&
                           ((r_cnt >= w_thresh_eff) || w_timeout_hit);

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        w_timer_nxt  = r_timer;
        w_hold_nxt   = r_hold;
        w_status_nxt = '0;

        if (!enable_i) begin
            w_state_nxt = IDLE;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_timer_nxt = '0;
            w_hold_nxt  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_acc_nxt = '0;
                    if (w_any) begin
                        w_acc_nxt   = w_det;
                        w_cnt_nxt   = CNT_W'(1);
                        w_timer_nxt = timeout_i;
                        w_state_nxt = COLLECT;
                    end
                end

                COLLECT: begin
                    if (w_fire) begin
                        // Events seen in the fire cycle ride along in this pulse.
                        w_status_nxt = w_acc_det;
                        w_acc_nxt    = '0;
                        w_cnt_nxt    = '0;
                        if (holdoff_i != '0) begin
                            w_hold_nxt  = holdoff_i;
                            w_state_nxt = HOLDOFF;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_acc_nxt   = w_acc_det;
                        w_cnt_nxt   = w_cnt_inc;
                        w_timer_nxt = (r_timer != '0) ? r_timer - TMR_W'(1) : r_timer;
                    end
                end

                HOLDOFF: begin
                    w_acc_nxt = w_acc_det;
                    w_cnt_nxt = w_cnt_inc;
                    if (r_hold == '0) begin
                        if (w_acc_det != '0) begin
                            w_timer_nxt = timeout_i;
                            w_state_nxt = COLLECT;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_hold_nxt = r_hold - TMR_W'(1);
                    end
                end

                default: begin
                    w_state_nxt = IDLE;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_timer_nxt = '0;
                    w_hold_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_timer    <= '0;
            r_hold     <= '0;
            r_status   <= '0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_acc      <= w_acc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_timer    <= w_timer_nxt;
            r_hold     <= w_hold_nxt;
            r_status   <= w_status_nxt;
            // A fire in the same cycle as a clear strobe keeps the bit set.
            r_pending  <= (r_pending & ~pend_clr_i) | w_status_nxt;
            r_overflow <= w_ovf_set | (r_overflow & ~ovf_clr_i);
        end
    end

    assign status_o    = r_status;
    assign pending_o   = r_pending;
    assign overflow_o  = r_overflow;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_irq_event_coalescer.sv
// Directed bench for irq_event_coalescer: a driver pushes expected status
// pulses (cycle, value) into a queue and a negedge monitor pops and compares.
module tb_irq_event_coalescer;
    import irq_pkg::*;

    localparam int STATUS_W = 32;
    localparam int CNT_W    = 8;
    localparam int TMR_W    = 16;

    logic                clk;
    logic                rstn;
    logic                enable;
    logic [STATUS_W-1:0] event_v;
    logic [STATUS_W-1:0] edge_en;
    logic [CNT_W-1:0]    thresh;
    logic [TMR_W-1:0]    timeout;
    logic [TMR_W-1:0]    holdoff;
    logic [STATUS_W-1:0] pend_clr;
    logic                ovf_clr;
    logic [STATUS_W-1:0] status;
    logic [STATUS_W-1:0] pending;
    logic                overflow;
    coal_state_t         dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0      = 0;

    logic [STATUS_W-1:0] exp_q[$];
    int                  exp_cyc_q[$];

    irq_event_coalescer #(
        .STATUS_W (STATUS_W),
        .CNT_W    (CNT_W),
        .TMR_W    (TMR_W)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .enable_i    (enable),
        .event_i     (event_v),
        .edge_en_i   (edge_en),
        .thresh_i    (thresh),
        .timeout_i   (timeout),
        .holdoff_i   (holdoff),
        .pend_clr_i  (pend_clr),
        .ovf_clr_i   (ovf_clr),
        .status_o    (status),
        .pending_o   (pending),
        .overflow_o  (overflow),
        .dbg_state_o (dbg_state)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // Monitor: every nonzero status pulse must match the head of the queue
    always @(negedge clk) begin
        if (rstn && status != '0) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL status_unexpected: got 0x%0h at rel cycle %0d, required no pulse",
                         status, cyc - t0);
            end else begin
                logic [STATUS_W-1:0] e_v;
                int                  e_c;
                e_v = exp_q.pop_front();
                e_c = exp_cyc_q.pop_front();
                if (status !== e_v || cyc != e_c)
                begin
                    n_fail++;
                    $display("FAIL status_pulse: got 0x%0h at rel cycle %0d, required 0x%0h at rel cycle %0d",
                             status, cyc - t0, e_v, e_c - t0);
                end
            end
        end
    end

    // Driver tasks
    task automatic at(input int t);
        while (cyc < t0 + t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_pulse(input int t, input logic [STATUS_W-1:0] v);
        exp_q.push_back(v);
        exp_cyc_q.push_back(t0 + t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (rel cycle %0d)", name, act, req, cyc - t0);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rstn     = 1'b0;
        enable   = 1'b1;
        event_v  = '0;
        edge_en  = '1;
        thresh   = 8'd1;
        timeout  = '0;
        holdoff  = '0;
        pend_clr = '0;
        ovf_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        t0   = cyc;
    endtask

    task automatic end_test(input string name);
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing: got %0d pulses still outstanding, required 0", name, exp_q.size());
            exp_q.delete();
            exp_cyc_q.delete();
        end
    endtask

    initial begin
        rstn = 1'b0;
        do_reset();

        // Reset state
        check("rst_status", status, 32'h0);
        check("rst_pending", pending, 32'h0);
        check("rst_overflow", {31'd0, overflow}, 32'h0);
        check("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});

        // Threshold fire, N+2 latency
        expect_pulse(12, 32'h8);
        at(10); event_v = 32'h8;
        at(14); check("thr_pending", pending, 32'h8);
        at(15); event_v = '0;
        end_test("thr");

        // Coalescing four single-cycle pulses into one vector
        do_reset();
        thresh = 8'd4;
        expect_pulse(15, 32'h27);
        at(10); event_v = 32'h01;
        at(11); event_v = 32'h02;
        at(12); event_v = 32'h04;
        at(13); event_v = 32'h20;
        at(14); event_v = '0;
        check("coal_state", {30'd0, dbg_state}, {30'd0, COLLECT});
        at(20); check("coal_pending", pending, 32'h27);
        end_test("coal");

        // Timeout fire
        do_reset();
        thresh  = 8'd200;
        timeout = 16'd5;
        expect_pulse(27, 32'h80);
        at(20); event_v = 32'h80;
        at(21); event_v = '0;
        at(26); check("tmo_pending_before", pending, 32'h0);
        at(30); check("tmo_pending_after", pending, 32'h80);
        end_test("tmo");

        // Holdoff separates fires
        do_reset();
        holdoff = 16'd10;
        expect_pulse(12, 32'h1);
        expect_pulse(24, 32'h2);
        at(10); event_v = 32'h1;
        at(11); event_v = '0;
        at(13); event_v = 32'h2;
        at(14); event_v = '0;
        at(18); check("hold_state", {30'd0, dbg_state}, {30'd0, HOLDOFF});
        at(26); check("hold_pending", pending, 32'h3);
        end_test("hold");

        // Level detect, counter saturation, overflow clear
        do_reset();
        thresh  = 8'd255;
        edge_en = ~32'h4;
        expect_pulse(266, 32'h4);
        at(10); event_v = 32'h4;
        at(265); check("sat_ovf_before", {31'd0, overflow}, 32'h0);
        at(267); check("sat_ovf_set", {31'd0, overflow}, 32'h1);
        at(310); event_v = '0;
        at(315); check("sat_ovf_held", {31'd0, overflow}, 32'h1);
        at(320); ovf_clr = 1'b1;
        at(321); ovf_clr = 1'b0;
        check("sat_ovf_clr", {31'd0, overflow}, 32'h0);
        end_test("sat");

        // Enable flush and no false edge on re-enable
        do_reset();
        thresh = 8'd3;
        at(10); event_v = 32'h10;
        at(11); event_v = '0; enable = 1'b0;
        check("flush_collect", {30'd0, dbg_state}, {30'd0, COLLECT});
        at(12); event_v = 32'h10;
        check("flush_idle", {30'd0, dbg_state}, {30'd0, IDLE});
        at(13); enable = 1'b1;
        at(16); check("flush_no_false_edge", {30'd0, dbg_state}, {30'd0, IDLE});
        event_v = '0;
        end_test("flush");

        // Async reset mid-batch clears everything at once
        do_reset();
        expect_pulse(12, 32'h1);
        at(10); event_v = 32'h1;
        at(11); event_v = '0;
        at(14); thresh = 8'd4;
        at(20); event_v = 32'h2;
        at(21); event_v = '0;
        at(22); check("arst_pre_pending", pending, 32'h1);
        #2; rstn = 1'b0;
        #1;
        check("arst_status", status, 32'h0);
        check("arst_pending", pending, 32'h0);
        check("arst_state", {30'd0, dbg_state}, {30'd0, IDLE});
        end_test("arst");

        // Write-1-to-clear racing a fire: set wins
        do_reset();
        expect_pulse(12, 32'h1);
        at(10); event_v = 32'h1;
        at(11); event_v = '0; pend_clr = 32'h1;
        at(12); pend_clr = '0;
        check("w1c_race", pending, 32'h1);
        at(14); pend_clr = 32'h1;
        at(15); pend_clr = '0;
        check("w1c_clear", pending, 32'h0);
        end_test("w1c");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
